hex_scan_display16: RTL and testbench

Drives a 16-bit register value onto a 4-digit, common-anode, multiplexed seven-segment display, one hex nibble per digit. This block is the output-side counterpart of the nibble-entry register: the entry register assembles four keyed nibbles into a 16-bit word, and this block takes such a word back out to the user as four hex digits. It captures the word into a shadow register on a load strobe. It scans the digits continuously, with a blanking gap at each digit change to suppress ghosting.

---
 rtl/hex_scan_display16_if.sv | 28 ++
 rtl/hex_scan_display16.sv | 142 ++++++++++++++
 tb/tb_hex_scan_display16.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/hex_scan_display16_if.sv
// hex_scan_display16_if: load/value bus and scanned display outputs.
// master drives load/value; slave returns shown/digit/an/seg.
interface hex_disp_if;
  logic        load;
  logic [15:0] value;
  logic [15:0] shown;
  logic [1:0]  digit;
  logic [3:0]  an;
  logic [6:0]  seg;

  modport master (
    output load,
    output value,
    input  shown,
    input  digit,
    input  an,
    input  seg
  );

  modport slave (
    input  load,
    input  value,
    output shown,
    output digit,
    output an,
    output seg
  );
endinterface

// File: rtl/hex_scan_display16.sv
// hex_scan_display16: 4-digit common-anode hex scanner with per-slot blanking.
// Ports: clk, rst (async, active-low), bus (slave: load, value -> shown, digit, an, seg).
// Optional: LEADING_ZERO_BLANK_EN darkens leading-zero digits 1..3.
module hex_scan_display16 #(
  parameter int DIV   = 50000,
  parameter int BLANK = 16
) (
  input  logic       clk,
  input  logic       rst,
  hex_disp_if.slave  bus
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic {
    S_BLANK,
    S_LIT
  } st_t;

  st_t         r_state;
  st_t         w_state_nx;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nx;
  logic [1:0]  r_digit;
  logic [1:0]  w_dig_nx;
  logic        w_wrap;
  logic [15:0] r_shown;
  logic [3:0]  r_an;
  logic [3:0]  w_an_nx;
  logic [6:0]  r_seg;
  logic [6:0]  w_seg_nx;
  logic [3:0]  w_nib;
  logic        w_sup;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_BLANK;
      r_cnt   <= '0;
      r_digit <= 2'd0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_digit <= w_dig_nx;
    end
  end

  // next state
  always_comb begin
    w_wrap   = (r_cnt == CW'(DIV - 1));
    w_cnt_nx = r_cnt + CW'(1);
    w_dig_nx = r_digit;
    if (w_wrap) begin
      w_cnt_nx = '0;
      w_dig_nx = r_digit + 2'd1;
    end
    w_state_nx = r_state;
    unique case (r_state)
      S_BLANK: begin
        if (w_cnt_nx >= CW'(BLANK))
          w_state_nx = S_LIT;
      end
      S_LIT: begin
        if (w_wrap)
          w_state_nx = S_BLANK;
      end
      default: w_state_nx = S_BLANK;
    endcase
  end

  // outputs for the post-edge (cnt, digit), using pre-edge shown
  always_comb begin
    w_nib = r_shown[3:0];
    unique case (w_dig_nx)
      2'd0: w_nib = r_shown[3:0];
      2'd1: w_nib = r_shown[7:4];
      2'd2: w_nib = r_shown[11:8];
      2'd3: w_nib = r_shown[15:12];
      default: w_nib = r_shown[3:0];
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    w_sup = 1'b0;
    unique case (w_dig_nx)
      2'd0: w_sup = 1'b0;
      2'd1: w_sup = (r_shown[15:4] == 12'h000);
      2'd2: w_sup = (r_shown[15:8] == 8'h00);
      2'd3: w_sup = (r_shown[15:12] == 4'h0);
      default: w_sup = 1'b0;
    endcase
`else
    w_sup = 1'b0;
`endif
    w_an_nx  = 4'hF;
    w_seg_nx = 7'h7F;
    if (w_state_nx == S_LIT && !w_sup) begin
      w_an_nx  = ~(4'b0001 << w_dig_nx);
      w_seg_nx = hex7(w_nib);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shown <= 16'h0000;
      r_an    <= 4'hF;
      r_seg   <= 7'h7F;
    end else begin
      if (bus.load)
        r_shown <= bus.value;
      r_an  <= w_an_nx;
      r_seg <= w_seg_nx;
    end
  end

  assign bus.shown = r_shown;
  assign bus.digit = r_digit;
  assign bus.an    = r_an;
  assign bus.seg   = r_seg;

endmodule

// File: tb/tb_hex_scan_display16.sv
// tb_hex_scan_display16: directed checks of the hex scanner, DIV=8 BLANK=2.
// Expected values are hand-derived from the decode table and slot timing.
module tb_hex_scan_display16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   e     = 0;
  int   n_vec = 0;
  int   n_err = 0;

  hex_disp_if bus ();

  hex_scan_display16 #(
    .DIV   (8),
    .BLANK (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic advance(input int tgt);
    for (int i = 0; i < 64 && (e % 32) != tgt; i++)
      tick();
  endtask

  task automatic scan(input logic [6:0] s0,
                      input logic [6:0] s1,
                      input logic [6:0] s2,
                      input logic [6:0] s3,
                      input logic [3:0] dark);
    logic [6:0] s [4];
    int c;
    int d;
    s[0] = s0;
    s[1] = s1;
    s[2] = s2;
    s[3] = s3;
    for (int i = 0; i < 32; i++) begin
      tick();
      c = e % 8;
      d = (e / 8) % 4;
      chk("digit", 16'(bus.digit), 16'(d));
      if (c < 2 || dark[d]) begin
        chk("an_dark", 16'(bus.an), 16'hF);
        chk("seg_dark", 16'(bus.seg), 16'h7F);
      end else begin
        chk("an_lit", 16'(bus.an), 16'(~(4'b0001 << d) & 4'hF));
        chk("seg_lit", 16'(bus.seg), 16'(s[d]));
      end
    end
  endtask

  initial begin
    logic [3:0] dk0;
    logic [3:0] dkF0;
`ifdef LEADING_ZERO_BLANK_EN
    dk0  = 4'b1110;
    dkF0 = 4'b1100;
`else
    dk0  = 4'b0000;
    dkF0 = 4'b0000;
`endif
    bus.load  = 1'b0;
    bus.value = 16'h0000;
    #1 rst = 1'b0;
    #2;
    chk("rst_shown", bus.shown, 16'h0000);
    chk("rst_digit", 16'(bus.digit), 16'h0);
    chk("rst_an", 16'(bus.an), 16'hF);
    chk("rst_seg", 16'(bus.seg), 16'h7F);
    @(negedge clk);
    rst = 1'b1;
    e = 0;
    scan(7'h40, 7'h40, 7'h40, 7'h40, 4'b0000);

    bus.load  = 1'b1;
    bus.value = 16'h1234;
    tick();
    bus.load = 1'b0;
    chk("ld1234", bus.shown, 16'h1234);
    advance(0);
    scan(7'h19, 7'h30, 7'h24, 7'h79, 4'b0000);

    advance(12);
    bus.load  = 1'b1;
    bus.value = 16'hABCD;
    tick();
    bus.load = 1'b0;
    chk("mid_shown", bus.shown, 16'hABCD);
    chk("mid_an0", 16'(bus.an), 16'hD);
    chk("mid_seg0", 16'(bus.seg), 16'h30);
    tick();
    chk("mid_an1", 16'(bus.an), 16'hD);
    chk("mid_seg1", 16'(bus.seg), 16'h46);

    advance(31);
    bus.load  = 1'b1;
    bus.value = 16'h0F00;
    tick();
    bus.load = 1'b0;
    chk("wrap_digit", 16'(bus.digit), 16'h0);
    chk("wrap_shown", bus.shown, 16'h0F00);
    chk("wrap_an", 16'(bus.an), 16'hF);
    chk("wrap_seg", 16'(bus.seg), 16'h7F);

    bus.load  = 1'b1;
    bus.value = 16'h0000;
    tick();
    bus.load = 1'b0;
    chk("ld0000", bus.shown, 16'h0000);
    advance(0);
    scan(7'h40, 7'h40, 7'h40, 7'h40, dk0);

    bus.load  = 1'b1;
    bus.value = 16'h00F0;
    tick();
    bus.load = 1'b0;
    chk("ld00F0", bus.shown, 16'h00F0);
    advance(0);
    scan(7'h40, 7'h0E, 7'h40, 7'h40, dkF0);

    bus.load  = 1'b1;
    bus.value = 16'h1234;
    tick();
    bus.load = 1'b0;
    advance(21);
    rst = 1'b0;
    #1;
    chk("mrst_an", 16'(bus.an), 16'hF);
    chk("mrst_seg", 16'(bus.seg), 16'h7F);
    chk("mrst_digit", 16'(bus.digit), 16'h0);
    chk("mrst_shown", bus.shown, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    e = 0;
    scan(7'h40, 7'h40, 7'h40, 7'h40, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
